// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/forwarding controller: forward selects,
// memory-wait FSM states and the forward-priority helper.
package hazard_pkg;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   typedef enum logic [1:0] {
      ST_RUN  = 2'b00,
      ST_WAIT = 2'b01,
      ST_TRAP = 2'b10
   } state_e;

   // The M stage holds the younger result, so it wins over W.
   function automatic logic [1:0] fwd_sel(input logic m_hit, input logic w_hit);
      logic [1:0] sel;
      if (m_hit) begin
         sel = FWD_M;
      end else if (w_hit) begin
         sel = FWD_W;
      end else begin
         sel = FWD_RF;
      end
      return sel;
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Data-memory request/ready handshake observed by the hazard controller.
interface hazard_ctrl_if;

   logic mem_req_m;
   logic mem_ready_m;

   modport master (output mem_req_m, output mem_ready_m);
   modport slave  (input  mem_req_m, input  mem_ready_m);

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and step enable.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         i_clk,
   input  logic         i_clr,
   input  logic         i_en,
   input  logic         i_inc,
   output logic [W-1:0] o_cnt
);

   localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
   localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

   logic [W-1:0] r_cnt;

   // Clear dominates; otherwise count enabled events and stick at all-ones.
   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         r_cnt <= {W{1'b0}};
      end else if (i_en && i_inc && (r_cnt != CNT_MAX)) begin
         r_cnt <= r_cnt + CNT_ONE;
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline: operand forwarding,
// load-use / redirect handling, data-memory wait freeze with sticky timeout trap.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_AW   = 5,
   parameter int MAX_WAIT = 16,
   parameter int CNT_W    = 16,
   parameter int FWD_D_EN = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_clk_en,
   input  logic [REG_AW-1:0] i_rs1_d,
   input  logic [REG_AW-1:0] i_rs2_d,
   input  logic [REG_AW-1:0] i_rs1_e,
   input  logic [REG_AW-1:0] i_rs2_e,
   input  logic [REG_AW-1:0] i_rd_e,
   input  logic [REG_AW-1:0] i_rd_m,
   input  logic [REG_AW-1:0] i_rd_w,
   input  logic              i_reg_write_m,
   input  logic              i_reg_write_w,
   input  logic              i_load_e,
   input  logic              i_redirect_e,
   hazard_ctrl_if.slave      i_mem,
   output logic [1:0]        o_fw_a_e,
   output logic [1:0]        o_fw_b_e,
   output logic              o_fw_a_d,
   output logic              o_fw_b_d,
   output logic              o_pc_stall,
   output logic              o_if_id_stall,
   output logic              o_if_id_flush,
   output logic              o_id_ex_stall,
   output logic              o_id_ex_flush,
   output logic              o_ex_mem_stall,
   output logic              o_mem_wb_flush,
   output logic              o_mem_timeout,
   output logic [CNT_W-1:0]  o_stall_cnt,
   output logic [CNT_W-1:0]  o_flush_cnt
);

   localparam int WC_W = $clog2(MAX_WAIT);
   localparam logic [REG_AW-1:0] REG_ZERO  = {REG_AW{1'b0}};
   localparam logic [WC_W-1:0]   WAIT_LAST = WC_W'(MAX_WAIT - 1);
   localparam logic [WC_W-1:0]   WAIT_ONE  = WC_W'(1);
   localparam logic [WC_W-1:0]   WAIT_ZERO = {WC_W{1'b0}};

   state_e          r_state;
   logic [WC_W-1:0] r_wait_cnt;
   logic            r_mem_timeout;

   logic w_m_valid, w_w_valid;
   logic w_lu, w_frz, w_trap;

   assign w_m_valid = i_reg_write_m && (i_rd_m != REG_ZERO);
   assign w_w_valid = i_reg_write_w && (i_rd_w != REG_ZERO);

   assign o_fw_a_e = fwd_sel(w_m_valid && (i_rd_m == i_rs1_e), w_w_valid && (i_rd_w == i_rs1_e));
   assign o_fw_b_e = fwd_sel(w_m_valid && (i_rd_m == i_rs2_e), w_w_valid && (i_rd_w == i_rs2_e));

   if (FWD_D_EN != 0) begin : g_fwd_d
      assign o_fw_a_d = w_w_valid && (i_rd_w == i_rs1_d);
      assign o_fw_b_d = w_w_valid && (i_rd_w == i_rs2_d);
   end else begin : g_no_fwd_d
      assign o_fw_a_d = 1'b0;
      assign o_fw_b_d = 1'b0;
   end

   assign w_lu   = i_load_e && (i_rd_e != REG_ZERO) && ((i_rd_e == i_rs1_d) || (i_rd_e == i_rs2_d));
   assign w_frz  = i_mem.mem_req_m && !i_mem.mem_ready_m;
   assign w_trap = (r_state == ST_TRAP);

   // Priority: trap/freeze hold everything, then redirect, then load-use.
   always_comb begin
      o_pc_stall     = 1'b0;
      o_if_id_stall  = 1'b0;
      o_if_id_flush  = 1'b0;
      o_id_ex_stall  = 1'b0;
      o_id_ex_flush  = 1'b0;
      o_ex_mem_stall = 1'b0;
      o_mem_wb_flush = 1'b0;
      if (w_trap || w_frz) begin
         o_pc_stall     = 1'b1;
         o_if_id_stall  = 1'b1;
         o_id_ex_stall  = 1'b1;
         o_ex_mem_stall = 1'b1;
         o_mem_wb_flush = 1'b1;
      end else if (i_redirect_e) begin
         o_if_id_flush = 1'b1;
         o_id_ex_flush = 1'b1;
      end else if (w_lu) begin
         o_pc_stall    = 1'b1;
         o_if_id_stall = 1'b1;
         o_id_ex_flush = 1'b1;
      end else begin
         o_pc_stall = 1'b0;
      end
   end

   // Memory-wait FSM; TRAP is left only through reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= ST_RUN;
         r_wait_cnt    <= WAIT_ZERO;
         r_mem_timeout <= 1'b0;
      end else if (i_clk_en) begin
         case (r_state)
            ST_RUN: begin
               if (w_frz) begin
                  r_state    <= ST_WAIT;
                  r_wait_cnt <= WAIT_ONE;
               end else begin
                  r_state    <= ST_RUN;
                  r_wait_cnt <= WAIT_ZERO;
               end
            end
            ST_WAIT: begin
               if (!w_frz) begin
                  r_state    <= ST_RUN;
                  r_wait_cnt <= WAIT_ZERO;
               end else if (r_wait_cnt == WAIT_LAST) begin
                  r_state       <= ST_TRAP;
                  r_mem_timeout <= 1'b1;
               end else begin
                  r_wait_cnt <= r_wait_cnt + WAIT_ONE;
               end
            end
            ST_TRAP: begin
               r_state       <= ST_TRAP;
               r_mem_timeout <= 1'b1;
            end
            default: begin
               r_state       <= ST_RUN;
               r_wait_cnt    <= WAIT_ZERO;
               r_mem_timeout <= 1'b0;
            end
         endcase
      end else begin
         r_state    <= r_state;
         r_wait_cnt <= r_wait_cnt;
      end
   end

   assign o_mem_timeout = r_mem_timeout;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .i_clk (i_clk),
      .i_clr (i_rst),
      .i_en  (i_clk_en),
      .i_inc (o_pc_stall),
      .o_cnt (o_stall_cnt)
   );

   // A redirect flush is "applied" only when nothing above it suppressed it.
   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .i_clk (i_clk),
      .i_clr (i_rst),
      .i_en  (i_clk_en),
      .i_inc (o_if_id_flush),
      .o_cnt (o_flush_cnt)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector scoreboard bench for hazard_ctrl (MAX_WAIT=4, CNT_W=4).
module tb_hazard_ctrl;

   localparam int AW = 5;
   localparam int MW = 4;
   localparam int CW = 4;

   localparam logic [6:0] C_NONE = 7'b0000000;
   localparam logic [6:0] C_LU   = 7'b1100100;
   localparam logic [6:0] C_RED  = 7'b0010100;
   localparam logic [6:0] C_FRZ  = 7'b1101011;

   typedef struct packed {
      logic          rst;
      logic          en;
      logic [AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
      logic          rwm, rww, ld, redir, req, rdy;
   } stim_t;

   typedef struct packed {
      logic [1:0]    fa, fb;
      logic          fad, fbd;
      logic [6:0]    ctl;
      logic          to;
      logic [CW-1:0] sc, fc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, clk_en;
   logic [AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
   logic          rwm, rww, ld, redir;
   logic [1:0]    fw_a_e, fw_b_e;
   logic          fw_a_d, fw_b_d;
   logic          pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
   logic          ex_mem_stall, mem_wb_flush, mem_timeout;
   logic [CW-1:0] stall_cnt, flush_cnt;

   hazard_ctrl_if u_if ();

   hazard_ctrl #(.REG_AW(AW), .MAX_WAIT(MW), .CNT_W(CW), .FWD_D_EN(1)) dut (
      .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en),
      .i_rs1_d(rs1_d), .i_rs2_d(rs2_d), .i_rs1_e(rs1_e), .i_rs2_e(rs2_e),
      .i_rd_e(rd_e), .i_rd_m(rd_m), .i_rd_w(rd_w),
      .i_reg_write_m(rwm), .i_reg_write_w(rww), .i_load_e(ld), .i_redirect_e(redir),
      .i_mem(u_if),
      .o_fw_a_e(fw_a_e), .o_fw_b_e(fw_b_e), .o_fw_a_d(fw_a_d), .o_fw_b_d(fw_b_d),
      .o_pc_stall(pc_stall), .o_if_id_stall(if_id_stall), .o_if_id_flush(if_id_flush),
      .o_id_ex_stall(id_ex_stall), .o_id_ex_flush(id_ex_flush),
      .o_ex_mem_stall(ex_mem_stall), .o_mem_wb_flush(mem_wb_flush),
      .o_mem_timeout(mem_timeout), .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
   );

   exp_t  exp_q[$];
   string name_q[$];
   int    n_err = 0;
   int    n_chk = 0;
   int    n_issued = 0;
   int    n_popped = 0;

   function automatic stim_t idle();
      stim_t s;
      s = '0;
      s.en = 1'b1;
      return s;
   endfunction

   function automatic exp_t mk(input logic [6:0] ctl, input logic to, input int sc, input int fc);
      exp_t e;
      e = '0;
      e.ctl = ctl;
      e.to  = to;
      e.sc  = CW'(sc);
      e.fc  = CW'(fc);
      return e;
   endfunction

   task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s.%s actual=%0h required=%0h", nm, fld, act, req);
      end
   endtask

   task automatic go(input string nm, input stim_t s, input exp_t e);
      @(posedge clk);
      #1;
      rst = s.rst;  clk_en = s.en;
      rs1_d = s.rs1_d; rs2_d = s.rs2_d; rs1_e = s.rs1_e; rs2_e = s.rs2_e;
      rd_e = s.rd_e; rd_m = s.rd_m; rd_w = s.rd_w;
      rwm = s.rwm; rww = s.rww; ld = s.ld; redir = s.redir;
      u_if.mem_req_m   = s.req;
      u_if.mem_ready_m = s.rdy;
      exp_q.push_back(e);
      name_q.push_back(nm);
      n_issued++;
   endtask

   // Monitor: outputs are sampled mid-cycle, one expectation per cycle.
   always @(negedge clk) begin
      exp_t  e;
      string nm;
      if (exp_q.size() > 0) begin
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         n_popped++;
         chk(nm, "fwd", 32'({fw_a_e, fw_b_e, fw_a_d, fw_b_d}), 32'({e.fa, e.fb, e.fad, e.fbd}));
         chk(nm, "ctl", 32'({pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                             ex_mem_stall, mem_wb_flush}), 32'(e.ctl));
         chk(nm, "timeout", 32'(mem_timeout), 32'(e.to));
         chk(nm, "cnt", 32'({stall_cnt, flush_cnt}), 32'({e.sc, e.fc}));
      end
   end

   initial begin
      stim_t s;
      exp_t  e;
      int    guard;
      rst = 1'b1; clk_en = 1'b1;
      rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0; rd_m = '0; rd_w = '0;
      rwm = 1'b0; rww = 1'b0; ld = 1'b0; redir = 1'b0;
      u_if.mem_req_m = 1'b0; u_if.mem_ready_m = 1'b0;
      repeat (3) @(posedge clk);

      go("reset_idle", idle(), mk(C_NONE, 1'b0, 0, 0));

      s = idle(); s.rd_m = 5'd5; s.rwm = 1'b1; s.rs1_e = 5'd5; s.rd_w = 5'd5; s.rww = 1'b1; s.rs2_d = 5'd5;
      e = mk(C_NONE, 1'b0, 0, 0); e.fa = 2'b10; e.fbd = 1'b1;
      go("fwd_m_prio", s, e);

      s = idle(); s.rd_m = 5'd0; s.rwm = 1'b1; s.rd_w = 5'd5; s.rww = 1'b1;
      s.rs1_e = 5'd5; s.rs2_e = 5'd5; s.rs1_d = 5'd5;
      e = mk(C_NONE, 1'b0, 0, 0); e.fa = 2'b01; e.fb = 2'b01; e.fad = 1'b1;
      go("fwd_w", s, e);

      s = idle(); s.rwm = 1'b1; s.rww = 1'b1;
      go("fwd_x0", s, mk(C_NONE, 1'b0, 0, 0));

      s = idle(); s.rd_m = 5'd3; s.rs1_e = 5'd4; s.rs2_e = 5'd3; s.rd_w = 5'd3; s.rww = 1'b1; s.rs2_d = 5'd3;
      e = mk(C_NONE, 1'b0, 0, 0); e.fb = 2'b01; e.fbd = 1'b1;
      go("fwd_m_off", s, e);

      s = idle(); s.ld = 1'b1; s.rd_e = 5'd7; s.rs2_d = 5'd7;
      go("load_use", s, mk(C_LU, 1'b0, 0, 0));
      go("after_lu", idle(), mk(C_NONE, 1'b0, 1, 0));

      s = idle(); s.ld = 1'b1; s.rd_e = 5'd7; s.rs1_d = 5'd7; s.redir = 1'b1;
      go("redir_lu", s, mk(C_RED, 1'b0, 1, 0));
      go("after_red", idle(), mk(C_NONE, 1'b0, 1, 1));

      s = idle(); s.redir = 1'b1;
      go("redir", s, mk(C_RED, 1'b0, 1, 1));

      s = idle(); s.ld = 1'b1; s.rs1_d = 5'd0;
      go("lu_x0", s, mk(C_NONE, 1'b0, 1, 2));

      s = idle(); s.req = 1'b1; s.redir = 1'b1;
      go("frz1_redir", s, mk(C_FRZ, 1'b0, 1, 2));
      s = idle(); s.req = 1'b1;
      go("frz2", s, mk(C_FRZ, 1'b0, 2, 2));
      go("frz3", s, mk(C_FRZ, 1'b0, 3, 2));
      s.rdy = 1'b1;
      go("frz_done", s, mk(C_NONE, 1'b0, 4, 2));
      go("run_again", idle(), mk(C_NONE, 1'b0, 4, 2));

      s = idle(); s.req = 1'b1; s.rdy = 1'b1;
      go("ready_same", s, mk(C_NONE, 1'b0, 4, 2));
      go("ready_same_idle", idle(), mk(C_NONE, 1'b0, 4, 2));

      s = idle(); s.req = 1'b1;
      go("wait_enter", s, mk(C_FRZ, 1'b0, 4, 2));
      s.en = 1'b0;
      for (int i = 0; i < 10; i++) go("en_off", s, mk(C_FRZ, 1'b0, 5, 2));
      s.en = 1'b1;
      go("wait_2", s, mk(C_FRZ, 1'b0, 5, 2));
      go("wait_3", s, mk(C_FRZ, 1'b0, 6, 2));
      go("wait_4", s, mk(C_FRZ, 1'b0, 7, 2));
      go("trap", idle(), mk(C_FRZ, 1'b1, 8, 2));

      s = idle(); s.redir = 1'b1;
      go("trap_redir", s, mk(C_FRZ, 1'b1, 9, 2));
      for (int i = 0; i < 8; i++) go("trap_sat", idle(), mk(C_FRZ, 1'b1, (10 + i > 15) ? 15 : 10 + i, 2));

      s = idle(); s.rst = 1'b1;
      go("rst_in_trap", s, mk(C_FRZ, 1'b1, 15, 2));
      go("rst_cleared", idle(), mk(C_NONE, 1'b0, 0, 0));

      s = idle(); s.req = 1'b1;
      for (int i = 0; i < 4; i++) go("to_frz", s, mk(C_FRZ, 1'b0, i, 0));
      go("timeout", idle(), mk(C_FRZ, 1'b1, 4, 0));

      guard = 0;
      while ((exp_q.size() > 0) && (guard < 10)) begin
         @(posedge clk);
         guard++;
      end
      @(posedge clk);
      #1;
      n_chk++;
      if (n_popped != n_issued) begin
         n_err++;
         $display("FAIL drain actual=%0d required=%0d", n_popped, n_issued);
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard and forwarding controller for the 5-stage RISC-V pipeline, the successor to the current hazard unit. It adds multi-cycle data-memory wait handling through a ready handshake, a sticky memory-timeout trap, and saturating stall/flush performance counters. Register-address width is configurable. It sits beside the data path and drives every pipeline-register stall, flush and forward-select line.

## Interface
Parameters:
- REG_AW, 5, register address width.
- MAX_WAIT, 16, memory-wait cycles before timeout (≥2).
- CNT_W, 16, performance counter width.
- FWD_D_EN, 1, enables W→D forwarding; 0 forces o_fw_*_d low.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high; one clock, all state on i_clk rising edge.
- i_clk_en  in  1  pipeline step enable; sequential state advances only when high.
- i_rs1_d, i_rs2_d, i_rs1_e, i_rs2_e  in  REG_AW  source registers, D and E.
- i_rd_e, i_rd_m, i_rd_w  in  REG_AW  destinations, E/M/W.
- i_reg_write_m, i_reg_write_w  in  1  writeback enables, M/W.
- i_load_e  in  1  E instruction is a load.
- i_redirect_e  in  1  taken branch or jump resolved in E.
- i_mem_req_m  in  1  M stage accessing data memory.
- i_mem_ready_m  in  1  memory completes access this cycle.
- o_fw_a_e, o_fw_b_e  out  2  00 regfile, 01 W result, 10 M ALU result.
- o_fw_a_d, o_fw_b_d  out  1  forward W result into D operand.
- o_pc_stall, o_if_id_stall, o_if_id_flush, o_id_ex_stall, o_id_ex_flush, o_ex_mem_stall, o_mem_wb_flush  out  1  pipeline controls.
- o_mem_timeout  out  1  sticky timeout flag.
- o_stall_cnt, o_flush_cnt  out  CNT_W  saturating counters.

## Operation
- Forwarding (combinational): for E operand X, 10 if i_reg_write_m && i_rd_m!=0 && i_rd_m==rsX_e; else 01 if same with W; else 00. M has priority. D forwarding: i_reg_write_w && i_rd_w!=0 && i_rd_w==rsX_d. Register 0 never forwards.
- Load-use: lu = i_load_e && i_rd_e!=0 && (i_rd_e==i_rs1_d || i_rd_e==i_rs2_d) → pc_stall, if_id_stall, id_ex_flush.
- Redirect: i_redirect_e → if_id_flush, id_ex_flush. Redirect and lu simultaneous: redirect wins, lu stall suppressed.
- Memory freeze: frz = i_mem_req_m && !i_mem_ready_m → pc, if_id, id_ex, ex_mem stall; mem_wb_flush; all flushes from lu/redirect suppressed (E held). frz overrides everything.
- FSM states RUN, WAIT, TRAP:
  - RUN→WAIT on frz; wait_cnt←1.
  - WAIT: ready or req dropped → RUN, wait_cnt←0; else wait_cnt+1; wait_cnt==MAX_WAIT-1 with frz → TRAP.
  - TRAP: all stall outputs and mem_wb_flush held 1 regardless of inputs; o_mem_timeout=1; exits only on i_rst.
- Counters: o_stall_cnt +1 each enabled cycle with o_pc_stall=1; o_flush_cnt +1 each enabled cycle with redirect flush actually applied. Both saturate at all-ones.
- i_clk_en=0: FSM, wait_cnt, counters hold; combinational outputs still follow inputs.

## Timing
- Forward selects and stall/flush controls: zero latency, combinational from inputs and registered state.
- FSM/counter updates take effect the cycle after the enabled edge.
- Reset values: state RUN, wait_cnt 0, counters 0, o_mem_timeout 0; with inputs idle every output is 0.
- Ready in the same cycle as req: no freeze, stays RUN.
- Reset during WAIT or TRAP: RUN next cycle, counters cleared.
- Timeout: frz held MAX_WAIT consecutive enabled cycles → o_mem_timeout high on following cycle.

## Structure
- Package hazard_pkg: fwd-select encodings (FWD_RF, FWD_W, FWD_M), FSM state enum.
- Sub-module sat_counter (width CNT_W, inc, clr, en), instantiated twice.

## Test plan
- rd_m=5, reg_write_m=1, rs1_e=5, rd_w=5, reg_write_w=1 → o_fw_a_e=10; rd_m=0 case → 01 from W; rs=0 → 00.
- Load in E, rd_e=7, rs2_d=7 → pc_stall=if_id_stall=id_ex_flush=1 for one cycle, o_stall_cnt=1.
- Redirect with lu both high → if_id_flush=id_ex_flush=1, pc_stall=0, o_flush_cnt=1.
- mem_req=1, ready low 3 cycles then high → 3 freeze cycles, ex_mem_stall and mem_wb_flush high, FSM back in RUN, o_stall_cnt=3.
- MAX_WAIT=4, ready never rises → o_mem_timeout=1 after 4 cycles, stalls stuck; i_rst clears everything.
- i_clk_en=0 during WAIT for 10 cycles → wait_cnt and counters unchanged, no timeout.
